// File: rtl/debug_pkg.sv
// Shared debug-module types: DMI register map, sbcs layout and the SBA FSM state.
package debug;

    typedef enum logic [7:0] {
        DMI_SBCS       = 8'h38,
        DMI_SBADDRESS0 = 8'h39,
        DMI_SBDATA0    = 8'h3C
    } dcsr_e;

    typedef enum logic [2:0] {
        SBV_LEGACY = 3'd0,
        SBV_1_0    = 3'd1
    } sbversion_e;

    typedef enum logic [2:0] {
        SBA_8BIT   = 3'd0,
        SBA_16BIT  = 3'd1,
        SBA_32BIT  = 3'd2,
        SBA_64BIT  = 3'd3,
        SBA_128BIT = 3'd4
    } sbaccess_e;

    typedef enum logic [2:0] {
        SBE_NONE      = 3'd0,
        SBE_TIMEOUT   = 3'd1,
        SBE_BADADDR   = 3'd2,
        SBE_ALIGNMENT = 3'd3,
        SBE_SIZE      = 3'd4,
        SBE_OTHER     = 3'd7
    } sberr_e;

    typedef struct packed {
        sbversion_e sbversion;
        logic [5:0] zero0;
        logic       busyerror;
        logic       busy;
        logic       readonaddr;
        sbaccess_e  access;
        logic       autoincrement;
        logic       readondata;
        sberr_e     error;
        logic [6:0] asize;
        logic       access128;
        logic       access64;
        logic       access32;
        logic       access16;
        logic       access8;
    } sbcs_t;

    typedef enum logic {
        SBA_IDLE = 1'b0,
        SBA_BUSY = 1'b1
    } sba_state_e;

    localparam int unsigned SBA_ADDR_W = 32;
    localparam logic [6:0]  SBA_ASIZE  = 7'd32;

    // Only byte, halfword and word accesses are implemented.
    function automatic logic sba_size_ok(input sbaccess_e acc);
        return (acc == SBA_8BIT) || (acc == SBA_16BIT) || (acc == SBA_32BIT);
    endfunction

    // Natural alignment check for the low address bits.
    function automatic logic sba_misaligned(input sbaccess_e acc, input logic [1:0] off);
        logic res;
        res = 1'b0;
        case (acc)
            SBA_16BIT: res = off[0];
            SBA_32BIT: res = |off;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

    // Address step for autoincrement.
    function automatic logic [SBA_ADDR_W-1:0] sba_bytes(input sbaccess_e acc);
        logic [SBA_ADDR_W-1:0] res;
        res = '0;
        case (acc)
            SBA_8BIT:  res = 32'd1;
            SBA_16BIT: res = 32'd2;
            SBA_32BIT: res = 32'd4;
            default:   res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/debug_sba_lane.sv
// Byte-lane steering for system bus accesses: byte enables, write replication, read extraction.
module debug_sba_lane
    import debug::*;
(
    input  logic [2:0]  access_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_c_o,
    output logic [31:0] wdata_c_o,
    output logic [31:0] rdata_c_o
);

    logic [31:0] shifted;

    // Shift read data down to lane 0, then select lanes by access size.
    always_comb begin
        shifted   = rdata_i >> {off_i, 3'b000};
        be_c_o    = '0;
        wdata_c_o = '0;
        rdata_c_o = '0;
        case (sbaccess_e'(access_i))
            SBA_8BIT: begin
                be_c_o    = 4'b0001 << off_i;
                wdata_c_o = {4{wdata_i[7:0]}};
                rdata_c_o = {24'd0, shifted[7:0]};
            end
            SBA_16BIT: begin
                be_c_o    = 4'b0011 << off_i;
                wdata_c_o = {2{wdata_i[15:0]}};
                rdata_c_o = {16'd0, shifted[15:0]};
            end
            SBA_32BIT: begin
                be_c_o    = 4'b1111;
                wdata_c_o = wdata_i;
                rdata_c_o = shifted;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/debug_sba.sv
// Debug-module system bus access block: sbcs/sbaddress0/sbdata0 over DMI, single-beat bus master.
// Optional bus timeout enabled by defining DEBUG_SBA_TIMEOUT_EN.
module debug_sba
    import debug::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmi_req_valid,
    input  logic [7:0]  dmi_addr,
    input  logic        dmi_write,
    input  logic [31:0] dmi_wdata,
    output logic        dmi_resp_valid,
    output logic [31:0] dmi_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);

    sba_state_e  state_q, state_d;
    logic        busyerror_q, busyerror_d;
    logic        readonaddr_q, readonaddr_d;
    sbaccess_e   access_q, access_d;
    logic        autoinc_q, autoinc_d;
    logic        readondata_q, readondata_d;
    sberr_e      error_q, error_d;
    logic [31:0] sbaddr_q, sbaddr_d;
    logic [31:0] sbdata_q, sbdata_d;
    sbaccess_e   op_access_q, op_access_d;
    logic [1:0]  op_off_q, op_off_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] rdata_q, rdata_d;

    logic        trig_c;
    logic        trig_we_c;
    logic [31:0] trig_addr_c;
    logic [31:0] trig_data_c;
    logic [31:0] rd_data_c;
    sbcs_t       sbcs_rd_c;
    sbaccess_e   lane_access_c;
    logic [1:0]  lane_off_c;
    logic [3:0]  lane_be_c;
    logic [31:0] lane_wdata_c;
    logic [31:0] lane_rdata_c;

`ifdef DEBUG_SBA_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    // Lanes follow the pending trigger when idle and the latched operation when busy.
    assign lane_access_c = (state_q == SBA_BUSY) ? op_access_q : access_q;
    assign lane_off_c    = (state_q == SBA_BUSY) ? op_off_q : trig_addr_c[1:0];

    debug_sba_lane u_lane (
        .access_i  (lane_access_c),
        .off_i     (lane_off_c),
        .wdata_i   (trig_data_c),
        .rdata_i   (bus_rdata),
        .be_c_o    (lane_be_c),
        .wdata_c_o (lane_wdata_c),
        .rdata_c_o (lane_rdata_c)
    );

    // DMI read mux; sbcs reports fixed capabilities plus live status.
    always_comb begin
        sbcs_rd_c               = '0;
        sbcs_rd_c.sbversion     = SBV_1_0;
        sbcs_rd_c.busyerror     = busyerror_q;
        sbcs_rd_c.busy          = (state_q == SBA_BUSY);
        sbcs_rd_c.readonaddr    = readonaddr_q;
        sbcs_rd_c.access        = access_q;
        sbcs_rd_c.autoincrement = autoinc_q;
        sbcs_rd_c.readondata    = readondata_q;
        sbcs_rd_c.error         = error_q;
        sbcs_rd_c.asize         = SBA_ASIZE;
        sbcs_rd_c.access32      = 1'b1;
        sbcs_rd_c.access16      = 1'b1;
        sbcs_rd_c.access8       = 1'b1;
        case (dmi_addr)
            DMI_SBCS:       rd_data_c = sbcs_rd_c;
            DMI_SBADDRESS0: rd_data_c = sbaddr_q;
            DMI_SBDATA0:    rd_data_c = sbdata_q;
            default:        rd_data_c = '0;
        endcase
    end

    // Decode which DMI access would start a bus operation, and with what address/data.
    always_comb begin
        trig_c      = 1'b0;
        trig_we_c   = 1'b0;
        trig_addr_c = sbaddr_q;
        trig_data_c = sbdata_q;
        if (dmi_req_valid && (state_q == SBA_IDLE)) begin
            case (dmi_addr)
                DMI_SBADDRESS0: begin
                    if (dmi_write && readonaddr_q) begin
                        trig_c      = 1'b1;
                        trig_addr_c = dmi_wdata;
                    end
                end
                DMI_SBDATA0: begin
                    if (dmi_write) begin
                        trig_c      = 1'b1;
                        trig_we_c   = 1'b1;
                        trig_data_c = dmi_wdata;
                    end else if (readondata_q) begin
                        trig_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state: register updates from DMI, FSM transitions and bus completion.
    always_comb begin
        state_d      = state_q;
        busyerror_d  = busyerror_q;
        readonaddr_d = readonaddr_q;
        access_d     = access_q;
        autoinc_d    = autoinc_q;
        readondata_d = readondata_q;
        error_d      = error_q;
        sbaddr_d     = sbaddr_q;
        sbdata_d     = sbdata_q;
        op_access_d  = op_access_q;
        op_off_d     = op_off_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        resp_valid_d = dmi_req_valid;
        rdata_d      = '0;
`ifdef DEBUG_SBA_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
`endif

        if (dmi_req_valid) begin
            if (!dmi_write) rdata_d = rd_data_c;
            case (dmi_addr)
                DMI_SBCS: begin
                    if (dmi_write) begin
                        busyerror_d  = busyerror_q & ~dmi_wdata[22];
                        readonaddr_d = dmi_wdata[20];
                        access_d     = sbaccess_e'(dmi_wdata[19:17]);
                        autoinc_d    = dmi_wdata[16];
                        readondata_d = dmi_wdata[15];
                        error_d      = sberr_e'(error_q & ~dmi_wdata[14:12]);
                    end
                end
                DMI_SBADDRESS0: begin
                    if (state_q == SBA_BUSY) busyerror_d = 1'b1;
                    else if (dmi_write)      sbaddr_d    = dmi_wdata;
                end
                DMI_SBDATA0: begin
                    if (state_q == SBA_BUSY) busyerror_d = 1'b1;
                    else if (dmi_write)      sbdata_d    = dmi_wdata;
                end
                default: ;
            endcase
        end

        case (state_q)
            SBA_IDLE: begin
                if (trig_c && !busyerror_q && (error_q == SBE_NONE)) begin
                    if (!sba_size_ok(access_q)) begin
                        error_d = SBE_SIZE;
                    end else if (sba_misaligned(access_q, trig_addr_c[1:0])) begin
                        error_d = SBE_ALIGNMENT;
                    end else begin
                        state_d     = SBA_BUSY;
                        op_access_d = access_q;
                        op_off_d    = trig_addr_c[1:0];
                        bus_req_d   = 1'b1;
                        bus_we_d    = trig_we_c;
                        bus_addr_d  = {trig_addr_c[31:2], 2'b00};
                        bus_be_d    = lane_be_c;
                        bus_wdata_d = trig_we_c ? lane_wdata_c : '0;
`ifdef DEBUG_SBA_TIMEOUT_EN
                        to_cnt_d    = '0;
`endif
                    end
                end
            end
            SBA_BUSY: begin
                if (bus_ack) begin
                    state_d     = SBA_IDLE;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = '0;
                    bus_be_d    = '0;
                    bus_wdata_d = '0;
                    if (bus_err) begin
                        error_d = SBE_OTHER;
                    end else begin
                        if (!bus_we_q) sbdata_d = lane_rdata_c;
                        if (autoinc_q) sbaddr_d = sbaddr_q + sba_bytes(op_access_q);
                    end
`ifdef DEBUG_SBA_TIMEOUT_EN
                end else if (to_cnt_q == TO_LAST) begin
                    state_d     = SBA_IDLE;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = '0;
                    bus_be_d    = '0;
                    bus_wdata_d = '0;
                    error_d     = SBE_TIMEOUT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
`endif
                end
            end
            default: state_d = SBA_IDLE;
        endcase
    end

    // State and register file, cleared by asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= SBA_IDLE;
            busyerror_q  <= 1'b0;
            readonaddr_q <= 1'b0;
            access_q     <= SBA_8BIT;
            autoinc_q    <= 1'b0;
            readondata_q <= 1'b0;
            error_q      <= SBE_NONE;
            sbaddr_q     <= '0;
            sbdata_q     <= '0;
            op_access_q  <= SBA_8BIT;
            op_off_q     <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
`ifdef DEBUG_SBA_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            busyerror_q  <= busyerror_d;
            readonaddr_q <= readonaddr_d;
            access_q     <= access_d;
            autoinc_q    <= autoinc_d;
            readondata_q <= readondata_d;
            error_q      <= error_d;
            sbaddr_q     <= sbaddr_d;
            sbdata_q     <= sbdata_d;
            op_access_q  <= op_access_d;
            op_off_q     <= op_off_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            resp_valid_q <= resp_valid_d;
            rdata_q      <= rdata_d;
`ifdef DEBUG_SBA_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    assign dmi_resp_valid = resp_valid_q;
    assign dmi_rdata      = rdata_q;
    assign bus_req        = bus_req_q;
    assign bus_we         = bus_we_q;
    assign bus_addr       = bus_addr_q;
    assign bus_be         = bus_be_q;
    assign bus_wdata      = bus_wdata_q;

endmodule

// File: tb/tb_debug_sba.sv
// Scoreboard bench for debug_sba: DMI responses and bus requests checked against queued expectations.
module tb_debug_sba;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dmi_req_valid = 1'b0;
    logic [7:0]  dmi_addr = '0;
    logic        dmi_write = 1'b0;
    logic [31:0] dmi_wdata = '0;
    logic        dmi_resp_valid;
    logic [31:0] dmi_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = '0;

    localparam logic [7:0] A_SBCS = 8'h38;
    localparam logic [7:0] A_ADDR = 8'h39;
    localparam logic [7:0] A_DATA = 8'h3C;

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
        string       tag;
    } dmi_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    dmi_exp_t dmi_q[$];
    bus_exp_t bus_q[$];
    bus_exp_t cur;
    int       n_tests = 0;
    int       n_fail  = 0;
    int       n_xfer  = 0;
    logic     prev_req = 1'b0;

    debug_sba #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .dmi_req_valid  (dmi_req_valid),
        .dmi_addr       (dmi_addr),
        .dmi_write      (dmi_write),
        .dmi_wdata      (dmi_wdata),
        .dmi_resp_valid (dmi_resp_valid),
        .dmi_rdata      (dmi_rdata),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_be         (bus_be),
        .bus_wdata      (bus_wdata),
        .bus_ack        (bus_ack),
        .bus_err        (bus_err),
        .bus_rdata      (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sbcs_val(input logic bsyerr, input logic bsy, input logic roa,
                                             input logic [2:0] acc, input logic ainc, input logic rod,
                                             input logic [2:0] err);
        return {3'd1, 6'd0, bsyerr, bsy, roa, acc, ainc, rod, err, 7'd32, 5'b00111};
    endfunction

    function automatic logic [31:0] sbcs_wr(input logic roa, input logic [2:0] acc, input logic ainc,
                                            input logic rod, input logic clr_be, input logic [2:0] clr_err);
        return {9'd0, clr_be, 1'b0, roa, acc, ainc, rod, clr_err, 12'd0};
    endfunction

    // DMI response monitor: pop expectation on every response strobe.
    always @(negedge clk) begin
        if (dmi_resp_valid) begin
            if (dmi_q.size() == 0) begin
                check("dmi_unexpected_resp", 32'd1, 32'd0);
            end else begin
                dmi_exp_t e;
                e = dmi_q.pop_front();
                if (e.is_rd) check(e.tag, dmi_rdata, e.data);
            end
        end
    end

    // Bus monitor: pop expectation on request rise, then require stable fields while held.
    always @(negedge clk) begin
        if (bus_req) begin
            if (!prev_req) begin
                n_xfer++;
                if (bus_q.size() == 0) begin
                    check("bus_unexpected_req", 32'd1, 32'd0);
                    cur = '{we: bus_we, addr: bus_addr, be: bus_be, wdata: bus_wdata};
                end else begin
                    cur = bus_q.pop_front();
                end
            end
            check("bus_we", 32'(bus_we), 32'(cur.we));
            check("bus_addr", bus_addr, cur.addr);
            check("bus_be", 32'(bus_be), 32'(cur.be));
            check("bus_wdata", cur.we ? bus_wdata : 32'd0, cur.we ? cur.wdata : 32'd0);
        end
        prev_req = bus_req;
    end

    // One DMI access; called at a falling edge, returns at the next one.
    task automatic dmi(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                       input logic [31:0] exp, input string tag);
        dmi_exp_t e;
        e = '{is_rd: !wr, data: exp, tag: tag};
        dmi_q.push_back(e);
        dmi_req_valid = 1'b1;
        dmi_write     = wr;
        dmi_addr      = a;
        dmi_wdata     = wd;
        @(negedge clk);
        dmi_req_valid = 1'b0;
        dmi_write     = 1'b0;
        check({tag, "_resp_valid"}, 32'(dmi_resp_valid), 32'd1);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] wd);
        dmi(1'b1, a, wd, 32'd0, "dmi_wr");
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
        dmi(1'b0, a, 32'd0, exp, tag);
    endtask

    // Bus slave: wait (bounded) for a request, hold off 'dly' cycles, then ack one cycle.
    task automatic respond(input int dly, input logic [31:0] rdat, input logic err);
        int n;
        n = 0;
        while (!bus_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus_req) begin
            check("bus_req_wait_expired", 32'd0, 32'd1);
        end else begin
            repeat (dly) @(negedge clk);
            bus_ack   = 1'b1;
            bus_err   = err;
            bus_rdata = rdat;
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_err   = 1'b0;
            bus_rdata = '0;
            check("bus_req_after_ack", 32'(bus_req), 32'd0);
        end
    endtask

    initial begin
        int x0;
        int hi;
        repeat (3) @(negedge clk);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_resp_valid", 32'(dmi_resp_valid), 32'd0);
        check("rst_rdata", dmi_rdata, 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rd(A_SBCS, 32'h2000_0407, "rst_sbcs");
        rd(A_ADDR, 32'd0, "rst_sbaddr");
        rd(A_DATA, 32'd0, "rst_sbdata");
        rd(8'h10, 32'd0, "unmapped_rd");

        // 32-bit write
        wr(A_SBCS, sbcs_wr(0, 3'd2, 0, 0, 0, 3'd0));
        wr(A_ADDR, 32'h0000_1000);
        bus_q.push_back('{we: 1'b1, addr: 32'h1000, be: 4'hF, wdata: 32'hDEAD_BEEF});
        wr(A_DATA, 32'hDEAD_BEEF);
        respond(2, 32'd0, 1'b0);
        rd(A_SBCS, sbcs_val(0, 0, 0, 3'd2, 0, 0, 3'd0), "w32_sbcs");
        rd(A_ADDR, 32'h1000, "w32_sbaddr");

        // 8-bit read on address write with autoincrement
        wr(A_SBCS, sbcs_wr(1, 3'd0, 1, 0, 0, 3'd0));
        bus_q.push_back('{we: 1'b0, addr: 32'h2000, be: 4'b1000, wdata: 32'd0});
        wr(A_ADDR, 32'h0000_2003);
        respond(1, 32'hAB00_0000, 1'b0);
        rd(A_DATA, 32'h0000_00AB, "r8_sbdata");
        rd(A_ADDR, 32'h0000_2004, "r8_sbaddr_inc");

        // misaligned 16-bit write
        wr(A_SBCS, sbcs_wr(0, 3'd1, 0, 0, 0, 3'd0));
        wr(A_ADDR, 32'h0000_3001);
        x0 = n_xfer;
        wr(A_DATA, 32'h0000_1234);
        repeat (3) @(negedge clk);
        check("align_no_req", 32'(n_xfer), 32'(x0));
        rd(A_SBCS, sbcs_val(0, 0, 0, 3'd1, 0, 0, 3'd3), "align_err");
        wr(A_SBCS, sbcs_wr(0, 3'd1, 0, 0, 0, 3'd7));
        rd(A_SBCS, sbcs_val(0, 0, 0, 3'd1, 0, 0, 3'd0), "align_w1c");

        // unsupported 64-bit size
        wr(A_SBCS, sbcs_wr(0, 3'd3, 0, 0, 0, 3'd0));
        wr(A_ADDR, 32'h0000_3000);
        wr(A_DATA, 32'h0000_0001);
        repeat (2) @(negedge clk);
        check("size_no_req", 32'(n_xfer), 32'(x0));
        rd(A_SBCS, sbcs_val(0, 0, 0, 3'd3, 0, 0, 3'd4), "size_err");
        wr(A_SBCS, sbcs_wr(0, 3'd2, 0, 0, 0, 3'd7));

        // access while busy
        wr(A_ADDR, 32'h0000_4000);
        x0 = n_xfer;
        bus_q.push_back('{we: 1'b1, addr: 32'h4000, be: 4'hF, wdata: 32'h1111_1111});
        wr(A_DATA, 32'h1111_1111);
        rd(A_SBCS, sbcs_val(0, 1, 0, 3'd2, 0, 0, 3'd0), "busy_sbcs");
        wr(A_DATA, 32'h2222_2222);
        rd(A_DATA, 32'h1111_1111, "busy_stale_rd");
        respond(0, 32'd0, 1'b0);
        rd(A_SBCS, sbcs_val(1, 0, 0, 3'd2, 0, 0, 3'd0), "busyerror_set");
        wr(A_DATA, 32'h1111_1111);
        repeat (3) @(negedge clk);
        check("busy_one_xfer", 32'(n_xfer), 32'(x0 + 1));
        wr(A_SBCS, sbcs_wr(0, 3'd2, 0, 0, 1, 3'd0));
        rd(A_SBCS, sbcs_val(0, 0, 0, 3'd2, 0, 0, 3'd0), "busyerror_w1c");

        // read on data read
        wr(A_SBCS, sbcs_wr(0, 3'd2, 1, 1, 0, 3'd0));
        wr(A_ADDR, 32'h0000_5000);
        bus_q.push_back('{we: 1'b0, addr: 32'h5000, be: 4'hF, wdata: 32'd0});
        rd(A_DATA, 32'h1111_1111, "rod_prev_data");
        respond(1, 32'hCAFE_F00D, 1'b0);
        wr(A_SBCS, sbcs_wr(0, 3'd2, 1, 0, 0, 3'd0));
        rd(A_DATA, 32'hCAFE_F00D, "rod_new_data");
        rd(A_ADDR, 32'h0000_5004, "rod_sbaddr_inc");

        // bus error
        wr(A_ADDR, 32'h0000_6000);
        bus_q.push_back('{we: 1'b1, addr: 32'h6000, be: 4'hF, wdata: 32'h55AA_55AA});
        wr(A_DATA, 32'h55AA_55AA);
        respond(1, 32'h0BAD_0BAD, 1'b1);
        rd(A_SBCS, sbcs_val(0, 0, 0, 3'd2, 1, 0, 3'd7), "buserr_err");
        rd(A_ADDR, 32'h0000_6000, "buserr_no_inc");
        wr(A_SBCS, sbcs_wr(0, 3'd2, 1, 0, 0, 3'd7));

        // autoincrement wrap, then 16-bit replicated write
        wr(A_ADDR, 32'hFFFF_FFFC);
        bus_q.push_back('{we: 1'b1, addr: 32'hFFFF_FFFC, be: 4'hF, wdata: 32'h0BAD_F00D});
        wr(A_DATA, 32'h0BAD_F00D);
        respond(0, 32'd0, 1'b0);
        rd(A_ADDR, 32'h0000_0000, "wrap_sbaddr");
        wr(A_SBCS, sbcs_wr(0, 3'd1, 1, 0, 0, 3'd0));
        wr(A_ADDR, 32'h0000_0002);
        bus_q.push_back('{we: 1'b1, addr: 32'h0, be: 4'b1100, wdata: 32'hBEEF_BEEF});
        wr(A_DATA, 32'h0000_BEEF);
        respond(1, 32'd0, 1'b0);
        rd(A_ADDR, 32'h0000_0004, "w16_sbaddr_inc");

        // no acknowledge
        wr(A_SBCS, sbcs_wr(0, 3'd2, 0, 0, 0, 3'd0));
        wr(A_ADDR, 32'h0000_7000);
        bus_q.push_back('{we: 1'b1, addr: 32'h7000, be: 4'hF, wdata: 32'h0000_0077});
        wr(A_DATA, 32'h0000_0077);
`ifdef DEBUG_SBA_TIMEOUT_EN
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_req) hi++;
            @(negedge clk);
        end
        check("timeout_req_cycles", 32'(hi), 32'd4);
        rd(A_SBCS, sbcs_val(0, 0, 0, 3'd2, 0, 0, 3'd1), "timeout_err");
        wr(A_SBCS, sbcs_wr(0, 3'd2, 0, 0, 0, 3'd7));
`else
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_req) hi++;
            @(negedge clk);
        end
        check("noack_req_held", 32'(hi), 32'd10);
        respond(0, 32'd0, 1'b0);
        rd(A_SBCS, sbcs_val(0, 0, 0, 3'd2, 0, 0, 3'd0), "noack_done");
`endif

        // reset during a transfer; a stray ack afterwards is ignored
        wr(A_ADDR, 32'h0000_8000);
        bus_q.push_back('{we: 1'b1, addr: 32'h8000, be: 4'hF, wdata: 32'h0000_0088});
        wr(A_DATA, 32'h0000_0088);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_bus_req", 32'(bus_req), 32'd0);
        rst = 1'b0;
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("stray_ack_bus_req", 32'(bus_req), 32'd0);
        rd(A_SBCS, 32'h2000_0407, "rst_mid_sbcs");
        rd(A_DATA, 32'd0, "rst_mid_sbdata");
        rd(A_ADDR, 32'd0, "rst_mid_sbaddr");

        repeat (2) @(negedge clk);
        check("dmi_q_empty", 32'(dmi_q.size()), 32'd0);
        check("bus_q_empty", 32'(bus_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
